// File: rtl/pc_next_pkg.sv
// Shared types and constants for the program-counter block: FSM states,
// default reset/trap vectors and the indices of the standard next-PC sources.
package pc_next_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } pc_state_e;

    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VECTOR  = 32'h0000_00FC;

    typedef enum int {
        PC_PLUS4   = 0,
        ALU_OUT    = 1,
        BRANCH     = 2,
        JUMP       = 3,
        EPC        = 4,
        MEM_VECTOR = 5
    } pc_src_idx_e;

endpackage

// File: rtl/pc_src_mux.sv
// Combinational NSRC-to-1 next-PC source selector with an out-of-range flag
// for select codes that do not map to a source.
module pc_src_mux
    import pc_next_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int NSRC  = 6,
    localparam int SELW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [SELW-1:0]       sel,
    output logic [WIDTH-1:0]      target,
    output logic                  out_of_range
);

    logic [31:0] sel_ext;

    always_comb begin
        target  = '0;
        sel_ext = 32'(sel);
        for (int k = 0; k < NSRC; k++) begin
            if (sel == SELW'(k)) begin
                target = src_data[k*WIDTH +: WIDTH];
            end
        end
        out_of_range = (sel_ext >= 32'(NSRC));
    end

endmodule

// File: rtl/pc_next_unit.sv
// Program counter with next-PC source select, conditional write, previous-PC
// capture and an optional misaligned-target trap (PC_NEXT_ALIGN_CHECK_EN).
module pc_next_unit
    import pc_next_pkg::*;
#(
    parameter  int               WIDTH        = 32,
    parameter  int               NSRC         = 6,
    parameter  logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
    parameter  logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(PC_TRAP_VECTOR),
    localparam int               SELW         = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [SELW-1:0]       pc_src,
    input  logic                  pc_write,
    input  logic                  pc_write_cond,
    input  logic                  cond,
    input  logic                  trap_ack,
    output logic [WIDTH-1:0]      pc,
    output logic [WIDTH-1:0]      pc_prev,
    output logic                  pc_updated,
    output logic                  sel_err,
    output logic                  trap,
    output logic [WIDTH-1:0]      bad_addr
);

    logic             load_req;
    logic [WIDTH-1:0] target;
    logic             out_of_range;

    assign load_req = pc_write | (pc_write_cond & cond);

    pc_src_mux #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC)
    ) u_src_mux (
        .src_data     (src_data),
        .sel          (pc_src),
        .target       (target),
        .out_of_range (out_of_range)
    );

`ifdef PC_NEXT_ALIGN_CHECK_EN
    pc_state_e        state;
    logic [WIDTH-1:0] bad_addr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            pc         <= RESET_VECTOR;
            pc_prev    <= '0;
            bad_addr_q <= '0;
            pc_updated <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            pc_updated <= 1'b0;
            sel_err    <= 1'b0;
            if (state == RUN) begin
                if (load_req) begin
                    if (out_of_range) begin
                        sel_err <= 1'b1;
                    end else if (target[1:0] != 2'b00) begin
                        pc         <= TRAP_VECTOR;
                        pc_prev    <= pc;
                        bad_addr_q <= target;
                        state      <= TRAP;
                        pc_updated <= 1'b1;
                    end else begin
                        pc         <= target;
                        pc_prev    <= pc;
                        pc_updated <= 1'b1;
                    end
                end
            end else begin
                // Any load presented alongside the ack is dropped.
                if (trap_ack) begin
                    state <= RUN;
                end
            end
        end
    end

    assign trap     = (state == TRAP);
    assign bad_addr = bad_addr_q;
`else
    logic unused_cfg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc         <= RESET_VECTOR;
            pc_prev    <= '0;
            pc_updated <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            pc_updated <= 1'b0;
            sel_err    <= 1'b0;
            if (load_req) begin
                if (out_of_range) begin
                    sel_err <= 1'b1;
                end else begin
                    pc         <= target;
                    pc_prev    <= pc;
                    pc_updated <= 1'b1;
                end
            end
        end
    end

    assign trap       = 1'b0;
    assign bad_addr   = '0;
    assign unused_cfg = trap_ack ^ (|TRAP_VECTOR);
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: table of vectors plus hand-written
// trap and asynchronous-reset sequences, checked through an expectation queue.
module tb_pc_next_unit;
    import pc_next_pkg::*;

    localparam int WIDTH = 32;
    localparam int NSRC  = 6;
    localparam int SELW  = 3;

    typedef struct {
        logic [SELW-1:0]  sel;
        logic             wr;
        logic             wrc;
        logic             cnd;
        logic             ack;
        logic [WIDTH-1:0] e_pc;
        logic [WIDTH-1:0] e_prev;
        logic             e_upd;
        logic             e_serr;
        logic             e_trap;
        logic [WIDTH-1:0] e_bad;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NSRC*WIDTH-1:0] src_data;
    logic [SELW-1:0]       pc_src;
    logic                  pc_write;
    logic                  pc_write_cond;
    logic                  cond;
    logic                  trap_ack;
    logic [WIDTH-1:0]      pc;
    logic [WIDTH-1:0]      pc_prev;
    logic                  pc_updated;
    logic                  sel_err;
    logic                  trap;
    logic [WIDTH-1:0]      bad_addr;

    logic [WIDTH-1:0] src [NSRC];
    vec_t             tbl [15];
    vec_t             exp_q [$];
    int               checks = 0;
    int               errors = 0;
    int               stepn  = 0;

    always #5 clk = ~clk;

    always_comb begin
        src_data = '0;
        for (int k = 0; k < NSRC; k++) begin
            src_data[k*WIDTH +: WIDTH] = src[k];
        end
    end

    pc_next_unit #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .src_data      (src_data),
        .pc_src        (pc_src),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .cond          (cond),
        .trap_ack      (trap_ack),
        .pc            (pc),
        .pc_prev       (pc_prev),
        .pc_updated    (pc_updated),
        .sel_err       (sel_err),
        .trap          (trap),
        .bad_addr      (bad_addr)
    );

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, stepn, act, exp);
        end
    endtask

    task automatic chk_outputs(input vec_t e);
        chk("pc", pc, e.e_pc);
        chk("pc_prev", pc_prev, e.e_prev);
        chk("pc_updated", {31'b0, pc_updated}, {31'b0, e.e_upd});
        chk("sel_err", {31'b0, sel_err}, {31'b0, e.e_serr});
        chk("trap", {31'b0, trap}, {31'b0, e.e_trap});
        chk("bad_addr", bad_addr, e.e_bad);
    endtask

    // Drive on the falling edge, queue the expectation, check 1 ns after the rising edge.
    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clk);
        pc_src        = v.sel;
        pc_write      = v.wr;
        pc_write_cond = v.wrc;
        cond          = v.cnd;
        trap_ack      = v.ack;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard step %0d: got empty queue expected one entry", stepn);
        end else begin
            e = exp_q.pop_front();
            chk_outputs(e);
        end
        stepn++;
    endtask

    function automatic vec_t mk(input logic [SELW-1:0] sel, input logic wr, input logic wrc,
                                input logic cnd, input logic ack, input logic [WIDTH-1:0] e_pc,
                                input logic [WIDTH-1:0] e_prev, input logic e_upd, input logic e_serr,
                                input logic e_trap, input logic [WIDTH-1:0] e_bad);
        vec_t v;
        v.sel = sel; v.wr = wr; v.wrc = wrc; v.cnd = cnd; v.ack = ack;
        v.e_pc = e_pc; v.e_prev = e_prev; v.e_upd = e_upd; v.e_serr = e_serr;
        v.e_trap = e_trap; v.e_bad = e_bad;
        return v;
    endfunction

    task automatic async_reset_check();
        vec_t r;
        @(negedge clk);
        pc_write = 1'b0; pc_write_cond = 1'b0; cond = 1'b0; trap_ack = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        r = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, PC_RESET_VECTOR, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_outputs(r);
        #1 reset_n = 1'b1;
        stepn++;
    endtask

    initial begin
        src[PC_PLUS4]   = 32'h0000_0004;
        src[ALU_OUT]    = 32'h0000_0040;
        src[BRANCH]     = 32'h0000_0080;
        src[JUMP]       = 32'h0000_0100;
        src[EPC]        = 32'h0000_0200;
        src[MEM_VECTOR] = 32'h0000_0300;

        //          sel    wr    wrc   cnd   ack   pc            prev          upd   serr  trap  bad
        tbl[0]  = mk(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0);
        tbl[1]  = mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0);
        tbl[2]  = mk(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0);
        tbl[3]  = mk(3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 32'h0);
        tbl[4]  = mk(3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0080, 32'h0000_0040, 1'b0, 1'b1, 1'b0, 32'h0);
        tbl[5]  = mk(3'd6, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0000_0040, 1'b0, 1'b1, 1'b0, 32'h0);
        tbl[6]  = mk(3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 32'h0);
        tbl[7]  = mk(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'h0000_0080, 1'b1, 1'b0, 1'b0, 32'h0);
        tbl[8]  = mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 32'h0);
        tbl[9]  = mk(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 32'h0);
        tbl[10] = mk(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0080, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 32'h0);
        tbl[11] = mk(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0080, 1'b1, 1'b0, 1'b0, 32'h0);
        tbl[12] = mk(3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'h0);
        tbl[13] = mk(3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0000_0200, 1'b1, 1'b0, 1'b0, 32'h0);
        tbl[14] = mk(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 32'h0);

        reset_n = 1'b0;
        pc_src = '0; pc_write = 1'b0; pc_write_cond = 1'b0; cond = 1'b0; trap_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk_outputs(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, PC_RESET_VECTOR, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));

        for (int i = 0; i < 15; i++) begin
            step(tbl[i]);
        end

        src[JUMP] = 32'h0000_0102;
`ifdef PC_NEXT_ALIGN_CHECK_EN
        // Misaligned jump traps; loads and bad selects are ignored until the ack.
        step(mk(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, PC_TRAP_VECTOR, 32'h0000_0300, 1'b1, 1'b0, 1'b1, 32'h0000_0102));
        step(mk(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, PC_TRAP_VECTOR, 32'h0000_0300, 1'b0, 1'b0, 1'b1, 32'h0000_0102));
        step(mk(3'd7, 1'b1, 1'b0, 1'b0, 1'b0, PC_TRAP_VECTOR, 32'h0000_0300, 1'b0, 1'b0, 1'b1, 32'h0000_0102));
        step(mk(3'd1, 1'b1, 1'b0, 1'b0, 1'b1, PC_TRAP_VECTOR, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 32'h0000_0102));
        step(mk(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040, PC_TRAP_VECTOR, 1'b1, 1'b0, 1'b0, 32'h0000_0102));
        step(mk(3'd3, 1'b0, 1'b1, 1'b1, 1'b0, PC_TRAP_VECTOR, 32'h0000_0040, 1'b1, 1'b0, 1'b1, 32'h0000_0102));
        async_reset_check();
`else
        // Without the check a misaligned target simply loads.
        step(mk(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0102, 32'h0000_0300, 1'b1, 1'b0, 1'b0, 32'h0));
        step(mk(3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0102, 1'b1, 1'b0, 1'b0, 32'h0));
        async_reset_check();
`endif
        step(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, PC_RESET_VECTOR, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
        step(mk(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0080, PC_RESET_VECTOR, 1'b1, 1'b0, 1'b0, 32'h0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Parametrised program-counter block for the multicycle datapath: an N-way next-PC source selector merged with the PC register, conditional-write logic, previous-PC capture and an optional misaligned-target trap. It sits between the ALU/branch/jump/exception address sources and the instruction memory address port. The control unit drives it each cycle with source select and write strobes.

## Interface
- WIDTH, 32: address width.
- NSRC, 6: number of next-PC sources, 2..8.
- SELW, derived ($clog2(NSRC), min 1): select width; localparam, not overridable.
- RESET_VECTOR, 32'h0000_0000: PC value after reset.
- TRAP_VECTOR, 32'h0000_00FC: PC loaded on a misalignment trap.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- src_data  in  NSRC*WIDTH  flattened sources; source k occupies bits [k*WIDTH +: WIDTH].
- pc_src  in  SELW  source select.
- pc_write  in  1  unconditional load request.
- pc_write_cond  in  1  conditional load request.
- cond  in  1  branch condition qualifying pc_write_cond.
- trap_ack  in  1  releases TRAP state.
- pc  out  WIDTH  current PC (registered).
- pc_prev  out  WIDTH  PC value before the most recent load.
- pc_updated  out  1  one-cycle pulse after a successful load.
- sel_err  out  1  one-cycle pulse after a rejected out-of-range select.
- trap  out  1  high while in TRAP state.
- bad_addr  out  WIDTH  misaligned target that caused the last trap.

## Operation
- load_req = pc_write | (pc_write_cond & cond).
- target = source pc_src, selected combinationally.
- FSM states: RUN, TRAP. Reset state is RUN.
- RUN, load_req, pc_src < NSRC, target aligned:
  - pc <= target; pc_prev <= pc; pc_updated = 1 next cycle.
- RUN, load_req, pc_src >= NSRC:
  - pc and pc_prev unchanged; sel_err = 1 next cycle; no trap.
- RUN, load_req, target[1:0] != 0 (macro on only):
  - pc <= TRAP_VECTOR; pc_prev <= pc; bad_addr <= target; state -> TRAP; pc_updated = 1 next cycle.
- TRAP:
  - All load requests ignored; no pulses generated.
  - trap_ack = 1 -> state RUN next cycle.
  - trap_ack together with load_req in the same cycle: the ack is honoured and the load is discarded.
- No load_req: all registers hold.
- pc_write and pc_write_cond both asserted: a single load occurs.

## Timing
- Reset (asynchronous, any cycle, including mid-trap): pc = RESET_VECTOR; pc_prev = 0; bad_addr = 0; pc_updated = 0; sel_err = 0; trap = 0; state = RUN.
- Load latency: 1 cycle. A request sampled at edge n gives the new pc visible after edge n; pc_updated is high for the cycle following edge n.
- pc_updated and sel_err are registered single-cycle pulses, never high together.
- trap rises in the same cycle that pc becomes TRAP_VECTOR. It falls one cycle after trap_ack is sampled.
- Back-to-back loads on consecutive cycles are supported. pc_updated then stays high continuously.

## Configuration
- PC_NEXT_ALIGN_CHECK_EN defined: word-alignment check, TRAP state, trap and bad_addr are active as described above.
- Not defined: every in-range target loads unchecked; trap is tied to 0; bad_addr is tied to 0; trap_ack is ignored; the FSM is reduced to RUN only.

## Structure
- Shared package pc_next_pkg holds:
  - the state enum (RUN, TRAP);
  - default RESET_VECTOR and TRAP_VECTOR constants;
  - the source index constants for the existing six encodings: PC_PLUS4 = 0, ALU_OUT = 1, BRANCH = 2, JUMP = 3, EPC = 4, MEM_VECTOR = 5.
- One sub-module: pc_src_mux, a parametrised purely combinational NSRC-to-1 selector that also outputs an out-of-range flag. The PC register, pc_prev, bad_addr and the FSM stay in the top module.

## Test plan
- Reset release, then pc_write = 1, pc_src = 1, source1 = 32'h0000_0040 -> next cycle pc = 32'h40, pc_prev = 0, pc_updated = 1 for one cycle.
- pc_write_cond = 1, cond = 0, source2 = 32'h80 -> pc unchanged, no pulse. Repeat with cond = 1 -> pc = 32'h80.
- NSRC = 6, pc_src = 7, pc_write = 1 -> pc unchanged; sel_err pulses once; pc_updated stays 0.
- Macro on: pc_src = 3, source3 = 32'h0000_0102 -> pc = 32'hFC, bad_addr = 32'h102, trap = 1. A further load is ignored. trap_ack = 1 -> trap = 0 next cycle.
- Macro on, in TRAP: reset_n pulsed low between edges -> pc = RESET_VECTOR and trap = 0 immediately, before the next clock edge.
- Loads on five consecutive cycles using sources 0..4 -> pc follows each target with 1-cycle latency, pc_prev lags by one load, pc_updated stays high continuously.
